// File: rtl/othello_scheduler.sv
`default_nettype none
// othello_scheduler: host-side task scheduler for a slot-interleaved Othello search pipeline.
// Rev 1.0: holding register, slot liveness tracking, credit-gated issue, FWFT result FIFO.

module othello_scheduler #(
    parameter int NSLOT        = 8,
    parameter int RES_DEPTH    = 8,
    parameter int PRIME_CYCLES = 16
) (
    input  logic        iCLOCK,
    input  logic        iRESET_N,
    input  logic        iStart,
    input  logic        iStop,
    input  logic        iTaskValid,
    output logic        oTaskReady,
    input  logic [63:0] iPlayer,
    input  logic [63:0] iOpponent,
    input  logic [15:0] iTaskid,
    output logic        oResValid,
    input  logic        iResReady,
    output logic [15:0] oResTaskid,
    output logic [7:0]  oResScore,
    output logic        oPipeEnable,
    output logic        oPipeValid,
    output logic [63:0] oPipePlayer,
    output logic [63:0] oPipeOpponent,
    output logic [15:0] oPipeTaskid,
    input  logic        iPipeTake,
    input  logic [2:0]  iPipeTakeSlot,
    input  logic        iPipeSolved,
    input  logic [2:0]  iPipeSlot,
    input  logic [15:0] iPipeTaskid,
    input  logic [7:0]  iPipeRes,
    output logic        oBusy,
    output logic [3:0]  oInFlight
);

    localparam int PCW = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES + 1) : 1;
    localparam int PW  = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CW  = $clog2(RES_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          state, next_state;
    logic [PCW-1:0]  prime_cnt;
    logic            prime_done;
    logic            ready_en;

    logic            hold_full;
    logic [63:0]     hold_player;
    logic [63:0]     hold_opponent;
    logic [15:0]     hold_taskid;

    logic [NSLOT-1:0] live, live_next;
    logic [3:0]       live_cnt;

    logic [23:0]     fifo_mem [RES_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty, fifo_full;
    logic            push, pop;

    logic            task_fire, pipe_fire, credit_ok, task_open;

    // ---------------- FSM ----------------
    always_ff @(posedge iCLOCK or negedge iRESET_N) begin
        if (!iRESET_N) state <= S_IDLE;
        else           state <= next_state;
    end

    assign prime_done = (prime_cnt == PCW'(PRIME_CYCLES - 1));

    always_comb begin
        next_state  = state;
        oPipeEnable = 1'b0;
        task_open   = 1'b1;
        unique case (state)
            S_IDLE:  if (iStart) next_state = S_PRIME;
            S_PRIME: if (prime_done) next_state = S_RUN;
            S_RUN: begin
                oPipeEnable = 1'b1;
                if (iStop) next_state = S_DRAIN;
            end
            S_DRAIN: begin
                oPipeEnable = 1'b1;
                task_open   = 1'b0;
                if (live_cnt == 4'd0 && fifo_empty) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK or negedge iRESET_N) begin
        if (!iRESET_N)             prime_cnt <= '0;
        else if (state != S_PRIME) prime_cnt <= '0;
        else if (!prime_done)      prime_cnt <= prime_cnt + 1'b1;
    end

    // Holds oTaskReady low while reset is asserted and until the first edge after release.
    always_ff @(posedge iCLOCK or negedge iRESET_N) begin
        if (!iRESET_N) ready_en <= 1'b0;
        else           ready_en <= 1'b1;
    end

    assign oBusy = (state != S_IDLE);

    // ---------------- Task holding register ----------------
    assign oTaskReady = ready_en && !hold_full && task_open;
    assign task_fire  = iTaskValid && oTaskReady;
    assign credit_ok  = (32'(live_cnt) + 32'(fifo_count)) < NSLOT;
    assign oPipeValid = hold_full && (state == S_RUN) && credit_ok;
    assign pipe_fire  = iPipeTake && oPipeValid;

    always_ff @(posedge iCLOCK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            hold_full     <= 1'b0;
            hold_player   <= '0;
            hold_opponent <= '0;
            hold_taskid   <= '0;
        end else begin
            if (pipe_fire) hold_full <= 1'b0;
            if (task_fire) begin
                hold_full     <= 1'b1;
                hold_player   <= iPlayer;
                hold_opponent <= iOpponent;
                hold_taskid   <= iTaskid;
            end
        end
    end

    assign oPipePlayer   = hold_player;
    assign oPipeOpponent = hold_opponent;
    assign oPipeTaskid   = hold_taskid;

    // ---------------- Slot liveness ----------------
    assign push = iPipeSolved && live[iPipeSlot];

    // Solve clears before take sets, so a same-slot take+solve retires the old task and keeps the slot live.
    always_comb begin
        live_next = live;
        if (push)      live_next[iPipeSlot]     = 1'b0;
        if (pipe_fire) live_next[iPipeTakeSlot] = 1'b1;
    end

    always_ff @(posedge iCLOCK or negedge iRESET_N) begin
        if (!iRESET_N) live <= '0;
        else           live <= live_next;
    end

    always_comb begin
        live_cnt = 4'd0;
        for (int i = 0; i < NSLOT; i++) live_cnt = live_cnt + {3'b000, live[i]};
    end

    assign oInFlight = live_cnt;

    // ---------------- Result FIFO (first-word fall-through) ----------------
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CW'(RES_DEPTH));
    assign pop        = !fifo_empty && iResReady;

    always_ff @(posedge iCLOCK) begin
        if (push) fifo_mem[wr_ptr] <= {iPipeTaskid, iPipeRes};
    end

    always_ff @(posedge iCLOCK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(RES_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PW'(RES_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign oResValid  = !fifo_empty;
    assign oResTaskid = fifo_empty ? 16'h0000 : fifo_mem[rd_ptr][23:8];
    assign oResScore  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr][7:0];

    a_no_overflow: assert property (@(posedge iCLOCK) disable iff (!iRESET_N)
        !(push && fifo_full && !pop));

endmodule

`default_nettype wire

// File: tb/tb_othello_scheduler.sv
`default_nettype none
// tb_othello_scheduler: directed, table-driven self-checking bench for othello_scheduler.

module tb_othello_scheduler;

    logic        clk, rst_n;
    logic        start, stop, tvalid, tready;
    logic [63:0] player, opponent;
    logic [15:0] tid;
    logic        rvalid, rready;
    logic [15:0] rtid;
    logic [7:0]  rscore;
    logic        pen, pvalid;
    logic [63:0] pplayer, popp;
    logic [15:0] ptid;
    logic        take;
    logic [2:0]  tslot;
    logic        solved;
    logic [2:0]  sslot;
    logic [15:0] stid;
    logic [7:0]  sres;
    logic        busy;
    logic [3:0]  infl;

    int checks   = 0;
    int failures = 0;

    othello_scheduler dut (
        .iCLOCK(clk), .iRESET_N(rst_n), .iStart(start), .iStop(stop),
        .iTaskValid(tvalid), .oTaskReady(tready), .iPlayer(player),
        .iOpponent(opponent), .iTaskid(tid), .oResValid(rvalid),
        .iResReady(rready), .oResTaskid(rtid), .oResScore(rscore),
        .oPipeEnable(pen), .oPipeValid(pvalid), .oPipePlayer(pplayer),
        .oPipeOpponent(popp), .oPipeTaskid(ptid), .iPipeTake(take),
        .iPipeTakeSlot(tslot), .iPipeSolved(solved), .iPipeSlot(sslot),
        .iPipeTaskid(stid), .iPipeRes(sres), .oBusy(busy), .oInFlight(infl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pp(input logic [15:0] t);
        return {t, ~t, t, 16'h5A5A};
    endfunction

    function automatic logic [63:0] po(input logic [15:0] t);
        return {4{t ^ 16'h0F0F}};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        start = 0; stop = 0; tvalid = 0; tid = '0; player = '0; opponent = '0;
        take = 0; tslot = '0; solved = 0; sslot = '0; stid = '0; sres = '0;
    endtask

    task automatic set_task(input logic v, input logic [15:0] t);
        tvalid = v; tid = t; player = pp(t); opponent = po(t);
    endtask

    // IDLE start pulse, 16 enable-low PRIME cycles, then RUN.
    task automatic prime_seq();
        clear_inputs();
        start = 1;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_enable", pen, 0);
        chk("idle_ready", tready, 1);
        step();
        start = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("prime_enable", pen, 0);
            chk("prime_busy", busy, 1);
            step();
        end
        #1;
        chk("run_enable", pen, 1);
        chk("run_busy", busy, 1);
        step();
    endtask

    typedef struct {
        logic        start, tvalid;
        logic [15:0] tid;
        logic        take;
        logic [2:0]  tslot;
        logic        solved;
        logic [2:0]  sslot;
        logic [15:0] stid;
        logic [7:0]  res;
        logic        rready;
        logic        e_ready, e_pv;
        logic [15:0] e_ptid;
        logic        e_rv;
        logic [15:0] e_rtid;
        logic [7:0]  e_rscore;
        logic [3:0]  e_infl;
    } vec_t;

    function automatic vec_t v(
        input logic st, input logic tv, input logic [15:0] t,
        input logic tk, input logic [2:0] ts,
        input logic sv, input logic [2:0] ss, input logic [15:0] sid, input logic [7:0] r,
        input logic rr,
        input logic er, input logic epv, input logic [15:0] ept,
        input logic erv, input logic [15:0] ert, input logic [7:0] ers, input logic [3:0] ei);
        vec_t x;
        x.start = st; x.tvalid = tv; x.tid = t; x.take = tk; x.tslot = ts;
        x.solved = sv; x.sslot = ss; x.stid = sid; x.res = r; x.rready = rr;
        x.e_ready = er; x.e_pv = epv; x.e_ptid = ept; x.e_rv = erv;
        x.e_rtid = ert; x.e_rscore = ers; x.e_infl = ei;
        return x;
    endfunction

    vec_t vecs[16];

    initial begin
        // st tv tid    tk ts sv ss stid   res    rr | rdy pv ptid  rv rtid   score  infl
        vecs[0]  = v(0, 1, 16'h0005, 0, 0, 0, 0, 16'h0000, 8'h00, 1, 1, 0, 16'h0000, 0, 16'h0000, 8'h00, 0);
        vecs[1]  = v(0, 0, 16'h0000, 1, 3, 0, 0, 16'h0000, 8'h00, 1, 0, 1, 16'h0005, 0, 16'h0000, 8'h00, 0);
        vecs[2]  = v(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h00, 1, 1, 0, 16'h0000, 0, 16'h0000, 8'h00, 1);
        vecs[3]  = v(0, 0, 16'h0000, 0, 0, 1, 3, 16'h0005, 8'h0C, 0, 1, 0, 16'h0000, 0, 16'h0000, 8'h00, 1);
        vecs[4]  = v(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 1, 0, 16'h0000, 1, 16'h0005, 8'h0C, 0);
        vecs[5]  = v(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h00, 1, 1, 0, 16'h0000, 1, 16'h0005, 8'h0C, 0);
        vecs[6]  = v(0, 0, 16'h0000, 0, 0, 1, 6, 16'h0077, 8'h03, 1, 1, 0, 16'h0000, 0, 16'h0000, 8'h00, 0);
        vecs[7]  = v(1, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h00, 1, 1, 0, 16'h0000, 0, 16'h0000, 8'h00, 0);
        vecs[8]  = v(0, 1, 16'h0020, 0, 0, 0, 0, 16'h0000, 8'h00, 1, 1, 0, 16'h0000, 0, 16'h0000, 8'h00, 0);
        vecs[9]  = v(0, 0, 16'h0000, 1, 2, 0, 0, 16'h0000, 8'h00, 1, 0, 1, 16'h0020, 0, 16'h0000, 8'h00, 0);
        vecs[10] = v(0, 1, 16'h0021, 0, 0, 0, 0, 16'h0000, 8'h00, 1, 1, 0, 16'h0000, 0, 16'h0000, 8'h00, 1);
        vecs[11] = v(0, 0, 16'h0000, 1, 2, 1, 2, 16'h0020, 8'hFB, 1, 0, 1, 16'h0021, 0, 16'h0000, 8'h00, 1);
        vecs[12] = v(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 1, 0, 16'h0000, 1, 16'h0020, 8'hFB, 1);
        vecs[13] = v(0, 0, 16'h0000, 0, 0, 1, 2, 16'h0021, 8'h7F, 1, 1, 0, 16'h0000, 1, 16'h0020, 8'hFB, 1);
        vecs[14] = v(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h00, 1, 1, 0, 16'h0000, 1, 16'h0021, 8'h7F, 0);
        vecs[15] = v(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h00, 1, 1, 0, 16'h0000, 0, 16'h0000, 8'h00, 0);

        // Reset: all outputs low, ready stays low until the first edge after release.
        rst_n = 0; rready = 0;
        clear_inputs();
        #1;
        chk("rst_ready", tready, 0);
        chk("rst_enable", pen, 0);
        chk("rst_pvalid", pvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_inflight", infl, 0);
        chk("rst_busy", busy, 0);
        step();
        chk("rst_ready_edge", tready, 0);
        rst_n = 1;
        #1;
        chk("release_ready_noedge", tready, 0);
        step();

        prime_seq();

        // Single task, dummy solve, same-slot take+solve, ignored iStart in RUN.
        for (int i = 0; i < 16; i++) begin
            clear_inputs();
            start = vecs[i].start;
            set_task(vecs[i].tvalid, vecs[i].tid);
            take = vecs[i].take; tslot = vecs[i].tslot;
            solved = vecs[i].solved; sslot = vecs[i].sslot;
            stid = vecs[i].stid; sres = vecs[i].res;
            rready = vecs[i].rready;
            #1;
            chk($sformatf("v%0d_ready", i), tready, vecs[i].e_ready);
            chk($sformatf("v%0d_enable", i), pen, 1);
            chk($sformatf("v%0d_pvalid", i), pvalid, vecs[i].e_pv);
            chk($sformatf("v%0d_rvalid", i), rvalid, vecs[i].e_rv);
            chk($sformatf("v%0d_inflight", i), infl, vecs[i].e_infl);
            if (vecs[i].e_pv) begin
                chk($sformatf("v%0d_ptid", i), ptid, vecs[i].e_ptid);
                chk($sformatf("v%0d_pplayer", i), pplayer, pp(vecs[i].e_ptid));
                chk($sformatf("v%0d_popp", i), popp, po(vecs[i].e_ptid));
            end
            if (vecs[i].e_rv) begin
                chk($sformatf("v%0d_rtid", i), rtid, vecs[i].e_rtid);
                chk($sformatf("v%0d_rscore", i), rscore, vecs[i].e_rscore);
            end
            step();
        end

        // Backpressure: eight results fill the FIFO, credit drops to zero.
        clear_inputs();
        rready = 0;
        for (int k = 0; k < 8; k++) begin
            clear_inputs();
            set_task(1, 16'h0100 + 16'(k));
            #1;
            chk("bp_ready", tready, 1);
            step();
            clear_inputs();
            take = 1; tslot = 3'(k);
            #1;
            chk("bp_pvalid", pvalid, 1);
            chk("bp_ptid", ptid, 16'h0100 + 16'(k));
            step();
            clear_inputs();
            solved = 1; sslot = 3'(k); stid = 16'h0100 + 16'(k); sres = 8'(k);
            #1;
            chk("bp_inflight", infl, 1);
            step();
        end
        clear_inputs();
        set_task(1, 16'h0200);
        #1;
        chk("full_accept_ready", tready, 1);
        chk("full_pvalid_empty", pvalid, 0);
        step();
        clear_inputs();
        take = 1; tslot = 3'd0;
        #1;
        chk("full_pvalid_held", pvalid, 0);
        chk("full_ready_held", tready, 0);
        chk("full_hold_tid", ptid, 16'h0200);
        chk("full_rvalid", rvalid, 1);
        step();
        clear_inputs();
        rready = 1;
        #1;
        chk("dummy_take_inflight", infl, 0);
        chk("drain0_pvalid", pvalid, 0);
        chk("drain0_rvalid", rvalid, 1);
        chk("drain0_rtid", rtid, 16'h0100);
        chk("drain0_rscore", rscore, 8'h00);
        step();
        for (int k = 1; k < 8; k++) begin
            #1;
            chk("drain_rvalid", rvalid, 1);
            chk("drain_rtid", rtid, 16'h0100 + 16'(k));
            chk("drain_rscore", rscore, 8'(k));
            if (k == 1) begin
                chk("resume_pvalid", pvalid, 1);
                chk("resume_ptid", ptid, 16'h0200);
            end
            step();
        end
        take = 1; tslot = 3'd0;
        #1;
        chk("drained_rvalid", rvalid, 0);
        chk("resume_take_pvalid", pvalid, 1);
        step();

        // Four live slots, enter DRAIN, then asynchronous reset.
        for (int k = 1; k < 4; k++) begin
            clear_inputs();
            set_task(1, 16'h0300 + 16'(k));
            step();
            clear_inputs();
            take = 1; tslot = 3'(k);
            step();
        end
        clear_inputs();
        stop = 1;
        #1;
        chk("live4_inflight", infl, 4);
        chk("stop_busy", busy, 1);
        step();
        clear_inputs();
        #1;
        chk("drain_ready", tready, 0);
        chk("drain_enable", pen, 1);
        chk("drain_inflight", infl, 4);
        rst_n = 0;
        #1;
        chk("arst_enable", pen, 0);
        chk("arst_pvalid", pvalid, 0);
        chk("arst_ready", tready, 0);
        chk("arst_rvalid", rvalid, 0);
        chk("arst_inflight", infl, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ptid", ptid, 0);
        step();
        rst_n = 1;
        step();

        prime_seq();

        // iStop in RUN with nothing outstanding: DRAIN for one cycle, then IDLE.
        clear_inputs();
        stop = 1;
        #1;
        chk("stop2_busy", busy, 1);
        step();
        clear_inputs();
        #1;
        chk("drain2_busy", busy, 1);
        chk("drain2_enable", pen, 1);
        chk("drain2_ready", tready, 0);
        step();
        #1;
        chk("idle2_busy", busy, 0);
        chk("idle2_enable", pen, 0);
        chk("idle2_ready", tready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/othello_scheduler.md
OTHELLO_SCHEDULER -- requirements
Module: othello_scheduler

Interface
REQ-001 SHALL have parameter NSLOT, default 8: number of pipeline context slots; slot indices are 3 bits wide.
REQ-002 SHALL have parameter RES_DEPTH, default 8: result FIFO depth; RES_DEPTH SHALL be >= NSLOT.
REQ-003 SHALL have parameter PRIME_CYCLES, default 16: enable-low cycles needed to bring every slot to start mode.
REQ-004 iCLOCK  in  1  single clock; every register SHALL update on its rising edge.
REQ-005 iRESET_N  in  1  asynchronous, active-low reset.
REQ-006 iStart  in  1  run request; sampled in IDLE only.
REQ-007 iStop  in  1  drain request; sampled in RUN only.
REQ-008 iTaskValid, oTaskReady, iPlayer[63:0], iOpponent[63:0], iTaskid[15:0]: host task input, valid/ready handshake.
REQ-009 oResValid, iResReady, oResTaskid[15:0], oResScore[7:0] signed: host result output, valid/ready handshake.
REQ-010 oPipeEnable, oPipeValid  out  1 each: pipeline enable, and task-present flag.
REQ-011 oPipePlayer[63:0], oPipeOpponent[63:0], oPipeTaskid[15:0]  out: task presented to the pipeline.
REQ-012 iPipeTake  in  1, and iPipeTakeSlot[2:0]  in: the pipeline latched the presented input into that slot this cycle.
REQ-013 iPipeSolved  in  1, iPipeSlot[2:0]  in, iPipeTaskid[15:0]  in, iPipeRes[7:0]  in: a root result left that slot.
REQ-014 oBusy  out  1 (state != IDLE); oInFlight[3:0]  out: count of live slots.

Function
REQ-015 FSM states SHALL be IDLE, PRIME, RUN, DRAIN.
REQ-016 IDLE->PRIME on iStart; PRIME->RUN after exactly PRIME_CYCLES cycles; RUN->DRAIN on iStop; DRAIN->IDLE when oInFlight==0 and the result FIFO is empty.
REQ-017 oPipeEnable SHALL be 1 only in RUN and DRAIN, and 0 in IDLE and PRIME.
REQ-018 Task holding register: one entry; oTaskReady = holding register empty AND state in {IDLE, PRIME, RUN}.
REQ-019 A task handshake (iTaskValid & oTaskReady) SHALL load the holding register on the next edge.
REQ-020 oPipeValid = holding register full AND state==RUN AND credit > 0, where credit = NSLOT - oInFlight - FIFO occupancy.
REQ-021 oPipePlayer, oPipeOpponent and oPipeTaskid SHALL come directly from the holding register.
REQ-022 iPipeTake with oPipeValid=1 SHALL empty the holding register and set live[iPipeTakeSlot].
REQ-023 iPipeTake with oPipeValid=0 SHALL leave live[] unchanged; the slot runs a dummy task.
REQ-024 iPipeSolved with live[iPipeSlot]=1 SHALL push {iPipeTaskid, iPipeRes} into the result FIFO and clear live[iPipeSlot].
REQ-025 iPipeSolved with live[iPipeSlot]=0 SHALL be discarded silently (dummy-task result).
REQ-026 Take and solve on the same slot in the same cycle: the solve is applied first (the previous task), then the take; live ends at 1.
REQ-027 oInFlight SHALL equal popcount(live); each take/solve SHALL be reflected one cycle after it.
REQ-028 Result FIFO: first-word fall-through; oResValid = not empty; pop on oResValid & iResReady.
REQ-029 A simultaneous push and pop SHALL keep occupancy unchanged, including when the FIFO is full.
REQ-030 The credit rule guarantees the FIFO never overflows; a push into a full FIFO is an error and SHALL be flagged by an assertion.
REQ-031 Read and write pointers SHALL wrap modulo RES_DEPTH.
REQ-032 iStart outside IDLE and iStop outside RUN SHALL be ignored.

Reset
REQ-033 On iRESET_N=0, asynchronously: state=IDLE, live=0, holding register empty, FIFO empty.
REQ-034 During reset all outputs SHALL be 0 (oPipeEnable=0, oPipeValid=0, oTaskReady=0, oResValid=0, oInFlight=0); any data in flight is dropped.
REQ-035 After reset deasserts, oTaskReady SHALL be 1 from the first clock edge.

Verification
REQ-036 Reset, iStart pulse -> oPipeEnable=0 for exactly 16 cycles, then 1; oBusy=1 throughout.
REQ-037 RUN, task id 0x0005 taken into slot 3, then iPipeSolved slot 3 with res=+12 -> one result {0x0005, +12}; oInFlight goes 0->1->0.
REQ-038 iPipeSolved on slot 6 while live[6]=0 -> no result; oResValid stays 0.
REQ-039 iResReady=0 and 8 tasks taken and solved -> oPipeValid=0 with holding register full; raising iResReady resumes issue in FIFO order.
REQ-040 Take and solve on slot 2 in the same cycle (live[2]=1) -> old result pushed; live[2]=1; oInFlight unchanged.
REQ-041 iRESET_N pulsed low with 4 tasks live -> all outputs 0 immediately; iStart afterwards behaves as in REQ-036.
